// File: rtl/alu_coef_loader.sv
// Coefficient-pair sequencer feeding the ALU multiply stage.
// Plays one (B, D) slot into the operand registers per request.
module alu_coef_loader #(
  parameter  int BUS_WIDTH = 8,
  parameter  int DEPTH     = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 wr_sel,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_slot,
  input  logic                 req_clr,
  output logic                 b_en,
  output logic                 d_en,
  output logic                 f_clr,
  output logic [BUS_WIDTH-1:0] imm,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_B,
    LOAD_D,
    DONE
  } state_t;

  state_t state, state_n;

  logic [BUS_WIDTH-1:0] b_tab [DEPTH];
  logic [BUS_WIDTH-1:0] d_tab [DEPTH];

  logic [ADDR_W-1:0]    slot, slot_n;
  logic                 clr, clr_n;
  logic                 b_en_n, d_en_n, f_clr_n, done_n;
  logic [BUS_WIDTH-1:0] imm_n;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  // Tables are read by the comb block below, so reads see pre-edge data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        b_tab[i] <= '0;
        d_tab[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel) d_tab[wr_addr] <= wr_data;
      else        b_tab[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= '0;
      clr   <= 1'b0;
      b_en  <= 1'b0;
      d_en  <= 1'b0;
      f_clr <= 1'b0;
      done  <= 1'b0;
      imm   <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      clr   <= clr_n;
      b_en  <= b_en_n;
      d_en  <= d_en_n;
      f_clr <= f_clr_n;
      done  <= done_n;
      imm   <= imm_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    clr_n   = clr;
    b_en_n  = 1'b0;
    d_en_n  = 1'b0;
    f_clr_n = 1'b0;
    done_n  = 1'b0;
    imm_n   = imm;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n = LOAD_B;
          slot_n  = req_slot;
          clr_n   = req_clr;
          b_en_n  = 1'b1;
          f_clr_n = req_clr;
          imm_n   = req_clr ? '0 : b_tab[req_slot];
        end
      end
      LOAD_B: begin
        state_n = LOAD_D;
        d_en_n  = 1'b1;
        f_clr_n = clr;
        imm_n   = clr ? '0 : d_tab[slot];
      end
      LOAD_D: begin
        state_n = DONE;
        done_n  = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_coef_loader.sv
// Self-checking bench for alu_coef_loader.
// Vector table plus scoreboard of expected enable strobes.
module tb_alu_coef_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       wr_sel;
  logic [7:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_slot;
  logic       req_clr;
  logic       b_en, d_en, f_clr, done, busy;
  logic [7:0] imm;

  alu_coef_loader #(.BUS_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_slot(req_slot), .req_clr(req_clr),
    .b_en(b_en), .d_en(d_en), .f_clr(f_clr),
    .imm(imm), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_d;
    logic       f;
    logic [7:0] imm;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [2:0] slot;
    logic       clr;
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] eb;
    logic [7:0] ed;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_b   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b_en) n_b++;
      if (b_en && d_en) begin
        n_err++;
        $display("FAIL both_en: b_en and d_en high at %0t", $time);
      end
      if (done && (b_en || d_en)) begin
        n_err++;
        $display("FAIL done_en: done with enable at %0t", $time);
      end
      if (busy !== ~req_ready) begin
        n_err++;
        $display("FAIL busy: got %b want %b", busy, ~req_ready);
      end
      if (b_en || d_en) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexp_en: b_en=%b d_en=%b imm=%h", b_en, d_en, imm);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("en_kind", {30'd0, b_en, d_en}, {30'd0, ~e.is_d, e.is_d});
          chk("f_clr", {31'd0, f_clr}, {31'd0, e.f});
          chk("imm", {24'd0, imm}, {24'd0, e.imm});
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic s, input logic [7:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_sel = s; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] s, input logic c,
                        input logic [7:0] eb, input logic [7:0] ed);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_slot = s; req_clr = c;
    q.push_back('{1'b0, c, eb});
    q.push_back('{1'b1, c, ed});
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_c1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("done_c3", {31'd0, done}, 32'd1);
    chk("imm_hold", {24'd0, imm}, {24'd0, ed});
    @(negedge clk);
    chk("ready_c4", {31'd0, req_ready}, 32'd1);
    chk("done_c4", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[8];
  logic exp_rdy[9];

  initial begin
    vecs[0] = '{1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 3'd3, 1'b0, 8'h40, 8'hC0, 8'h40, 8'hC0};
    vecs[2] = '{1'b0, 3'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 3'd3, 1'b0, 8'h00, 8'h00, 8'h40, 8'hC0};
    vecs[4] = '{1'b1, 3'd1, 1'b0, 8'h80, 8'h7F, 8'h80, 8'h7F};
    vecs[5] = '{1'b1, 3'd2, 1'b0, 8'h01, 8'hFF, 8'h01, 8'hFF};
    vecs[6] = '{1'b1, 3'd7, 1'b0, 8'hAA, 8'h55, 8'hAA, 8'h55};
    vecs[7] = '{1'b0, 3'd4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sel = 1'b0;
    wr_data = '0; req_valid = 1'b0; req_slot = '0; req_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {28'd0, b_en, d_en, f_clr, done}, 32'd0);
    chk("rst_imm", {24'd0, imm}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].slot, 1'b0, vecs[i].b);
        wr(vecs[i].slot, 1'b1, vecs[i].d);
      end
      do_req(vecs[i].slot, vecs[i].clr, vecs[i].eb, vecs[i].ed);
    end

    // Held request over two slots: accepted in cycles 0 and 4.
    n_b = 0;
    @(negedge clk);
    req_valid = 1'b1; req_slot = 3'd1; req_clr = 1'b0;
    q.push_back('{1'b0, 1'b0, 8'h80});
    q.push_back('{1'b1, 1'b0, 8'h7F});
    q.push_back('{1'b0, 1'b0, 8'h01});
    q.push_back('{1'b1, 1'b0, 8'hFF});
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_slot = 3'd2;
      if (c == 5) req_valid = 1'b0;
      chk("bp_ready", {31'd0, req_ready}, {31'd0, exp_rdy[c]});
      chk("bp_b_en", {31'd0, b_en}, {31'd0, (c == 1 || c == 5)});
    end
    repeat (3) @(negedge clk);
    chk("bp_count", n_b, 32'd2);

    // Write collisions around the slot-5 sequence.
    wr(3'd5, 1'b0, 8'h11);
    wr(3'd5, 1'b1, 8'h22);
    @(negedge clk);
    req_valid = 1'b1; req_slot = 3'd5; req_clr = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_sel = 1'b1; wr_data = 8'h7F;
    q.push_back('{1'b0, 1'b0, 8'h11});
    q.push_back('{1'b1, 1'b0, 8'h7F});
    @(negedge clk);
    req_valid = 1'b0; wr_sel = 1'b0; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);

    wr(3'd6, 1'b0, 8'h21);
    wr(3'd6, 1'b1, 8'h31);
    @(negedge clk);
    req_valid = 1'b1; req_slot = 3'd6; req_clr = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd6; wr_sel = 1'b0; wr_data = 8'h99;
    q.push_back('{1'b0, 1'b0, 8'h21});
    q.push_back('{1'b1, 1'b0, 8'h31});
    @(negedge clk);
    req_valid = 1'b0; wr_en = 1'b0;
    repeat (3) @(negedge clk);
    do_req(3'd5, 1'b0, 8'h55, 8'h7F);
    do_req(3'd6, 1'b0, 8'h99, 8'h31);

    // Reset asserted during LOAD_B.
    @(negedge clk);
    req_valid = 1'b1; req_slot = 3'd3; req_clr = 1'b0;
    q.push_back('{1'b0, 1'b0, 8'h40});
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_b_en", {31'd0, b_en}, 32'd0);
    chk("mid_rst_imm", {24'd0, imm}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, d_en, done, req_ready}, 32'd1);
    end
    do_req(3'd3, 1'b0, 8'h00, 8'h00);
    do_req(3'd5, 1'b0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_coef_loader.md
Name: alu_coef_loader

Overview:
- Sequencer that drives the coefficient-load side of the ALU multiply stage: `b_en`, `d_en`, `f_clr` and `imm`.
- Holds a small table of signed Q0.7 coefficient pairs (B, D), written by the control path.
- On a handshake request it plays one slot into the multiply stage's two operand registers over two consecutive cycles, then signals completion.
- Sits between the control/decode logic and the multiply stage; it replaces direct immediate loads.

Parameters:
- BUS_WIDTH, 8, width of each coefficient and of `imm`.
- DEPTH, 8, number of coefficient-pair slots; must be a power of 2, >= 2.
- ADDR_W, $clog2(DEPTH), slot index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  slot to write
- wr_sel  in  1  0 = write B entry, 1 = write D entry
- wr_data  in  BUS_WIDTH  coefficient value (Q0.7)
- req_valid  in  1  load request
- req_ready  out  1  loader idle, can accept a request
- req_slot  in  ADDR_W  slot to play out
- req_clr  in  1  1 = clear both downstream operands instead of loading the table
- b_en  out  1  enable for the downstream B operand register
- d_en  out  1  enable for the downstream D operand register
- f_clr  out  1  downstream clear qualifier, valid while `b_en` or `d_en` is high
- imm  out  BUS_WIDTH  coefficient presented to the downstream stage
- done  out  1  one-cycle pulse when both operands have been written
- busy  out  1  equal to ~req_ready

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; all 2*DEPTH table entries = 0.
  - b_en, d_en, f_clr, done = 0; imm = 0; req_ready = 1 (combinational from state).
  - Reset asserted mid-sequence aborts it immediately; no further enables are issued after release.
- FSM states: IDLE, LOAD_B, LOAD_D, DONE.
  - IDLE: req_ready = 1. On req_valid at a clk edge, latch req_slot and req_clr, then go to LOAD_B.
  - LOAD_B -> LOAD_D -> DONE -> IDLE, unconditionally, one cycle each.
  - req_valid while not IDLE is ignored and is not queued. The requester must hold req_valid until it sees ready.
- Outputs are registered, set on the edge entering each state:
  - LOAD_B: b_en = 1, d_en = 0, imm = clr ? 0 : B[slot], f_clr = clr.
  - LOAD_D: b_en = 0, d_en = 1, imm = clr ? 0 : D[slot], f_clr = clr.
  - DONE: done = 1; enables and f_clr = 0; imm holds its last value.
  - IDLE: all strobes 0; imm holds.
- Latency: handshake edge at cycle 0.
  - Cycle 1 has b_en; the downstream B register updates at the end of cycle 1.
  - Cycle 2 has d_en.
  - Cycle 3 has done.
  - req_ready is 1 again in cycle 4; back-to-back requests run every 4 cycles.
- Table writes:
  - Accepted in any state, including during a sequence.
  - The table is read on the edge entering LOAD_B or LOAD_D, with read-before-write at that edge.
  - A write to D[slot] during the LOAD_B cycle is therefore visible in LOAD_D.
  - A write to B[slot] on the entering-LOAD_B edge is not visible in LOAD_B.
- Clear semantics: when req_clr = 1, the table contents are not used and are not modified; f_clr is driven with imm = 0 on both strobes.
- No arithmetic is done here. Coefficients pass through bit-exact, two's complement Q0.7: 0x80 = -1.0, 0x7F = +0.992.
- Invariants:
  - b_en and d_en are never high in the same cycle.
  - done is never high in the same cycle as either enable.
  - Exactly one b_en and one d_en per accepted request.

Test Plan:
- Reset: hold rst_n = 0, then release.
  - Expect req_ready = 1 and b_en = d_en = f_clr = done = 0, imm = 0.
  - A request to slot 0 then yields imm = 0x00, 0x00.
- Basic load: write B[3] = 0x40, D[3] = 0xC0, then request slot 3, clr = 0.
  - Cycle 1: b_en = 1, imm = 0x40. Cycle 2: d_en = 1, imm = 0xC0. Cycle 3: done = 1. Cycle 4: req_ready = 1.
  - With the multiply stage attached and data_a = 100, data_b = 100: mult_a = 50, mult_b = -50.
- Clear: request slot 3 with clr = 1.
  - Cycles 1 and 2 have f_clr = 1 and imm = 0, with b_en then d_en.
  - B[3] still reads 0x40 on a later non-clear request.
- Busy/backpressure: hold req_valid = 1 continuously over slots 1, 2.
  - Exactly two sequences, 4 cycles apart.
  - req_ready = 0 during cycles 1–3 of each sequence; no extra enables.
- Write collision: during LOAD_B of slot 5, write D[5] = 0x7F.
  - LOAD_D presents imm = 0x7F.
  - A write to B[5] during LOAD_D leaves this sequence unchanged.
- Reset mid-op: assert rst_n low in the LOAD_B cycle.
  - Outputs drop to 0 asynchronously.
  - After release: no d_en and no done; req_ready = 1; table entries read back 0.
